// File: rtl/dvp_sensor_emulator.sv
// dvp_sensor_emulator: OV7670-style Pclk/Vsync/Href/Imagen source with built-in test patterns or frame-buffer readout.
module dvp_sensor_emulator #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_HALF   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  input  logic [7:0]  dat_i,
  output logic [18:0] adr_o,
  output logic        Pclk,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Imagen,
  output logic [7:0]  frame_cnt,
  output logic        busy
);
  localparam int PW = $clog2(PCLK_HALF);
  localparam logic [PW-1:0] PH_L = PW'(PCLK_HALF - 1);
  localparam logic [15:0] XL = 16'(H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] HA = 16'(H_ACTIVE);
  localparam logic [15:0] BL = 16'(H_ACTIVE / 8 - 1);
  localparam logic [63:0] BARS = 64'hFF_E0_1C_03_FC_1F_E3_00;
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  state_t r_state, w_nst;
  logic [PW-1:0] r_ph;
  logic [15:0] r_x, r_y, r_bcnt, w_nx, w_ny, w_last, w_bcnt;
  logic [2:0] r_bar, w_bar;
  logic [1:0] r_mode;
  logic [18:0] r_acnt;
  logic [7:0] w_pix;
  logic w_wrap, w_fall, w_rise, w_eol, w_eos, w_act, w_start, w_bend;
  assign w_wrap = r_ph == PH_L;
  assign w_fall = w_wrap & Pclk;
  assign w_rise = w_wrap & ~Pclk;
  // Next raster position: what the coming fall event will present.
  always_comb begin
    w_last = 16'((r_state == VSYNC ? VSYNC_LINES : r_state == VBACK ? V_BACK :
                  r_state == ACTIVE ? V_ACTIVE : V_FRONT) - 1);
    w_eol = r_x == XL;
    w_eos = w_eol && r_y == w_last;
    w_nst = r_state == IDLE ? (en ? VSYNC : IDLE) :
            !w_eos ? r_state :
            r_state == VSYNC ? VBACK :
            r_state == VBACK ? ACTIVE :
            r_state == ACTIVE ? VFRONT : (en ? VSYNC : IDLE);
    w_nx = (r_state == IDLE || w_eol) ? '0 : r_x + 16'd1;
    w_ny = (r_state == IDLE || w_eos) ? '0 : r_y + 16'(w_eol);
    w_act = w_nst == ACTIVE && w_nx < HA;
    w_start = w_nst == VSYNC && (r_state == IDLE || w_eos);
    w_bend = r_bcnt == BL;
    w_bar = w_nx == '0 ? '0 : r_bar + 3'(w_bend);
    w_bcnt = (w_nx == '0 || w_bend) ? '0 : r_bcnt + 16'd1;
    w_pix = r_mode == 2'd0 ? BARS[{~w_bar, 3'b000} +: 8] :
            r_mode == 2'd1 ? w_nx[7:0] :
            r_mode == 2'd2 ? frame_cnt : dat_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph <= '0;
      Pclk <= 1'b0;
      Vsync <= 1'b0;
      Href <= 1'b0;
      Imagen <= '0;
      busy <= 1'b0;
      frame_cnt <= '0;
      adr_o <= '0;
      r_state <= IDLE;
      r_x <= '0;
      r_y <= '0;
      r_bar <= '0;
      r_bcnt <= '0;
      r_mode <= '0;
      r_acnt <= '0;
    end else begin
      r_ph <= w_wrap ? '0 : r_ph + PW'(1);
      if (w_wrap) Pclk <= ~Pclk;
      if (w_rise && w_act) begin
        adr_o <= r_acnt;
        r_acnt <= r_acnt + 19'd1;
      end
      if (w_fall) begin
        r_state <= w_nst;
        r_x <= w_nx;
        r_y <= w_ny;
        Vsync <= w_nst == VSYNC;
        Href <= w_act;
        busy <= w_nst != IDLE;
        Imagen <= w_act ? w_pix : '0;
        if (w_act) begin
          r_bar <= w_bar;
          r_bcnt <= w_bcnt;
        end
        if (r_state == VFRONT && w_eos) frame_cnt <= frame_cnt + 8'd1;
        if (w_start) begin
          r_mode <= pat_sel;
          adr_o <= '0;
          r_acnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dvp_sensor_emulator.sv
// tb_dvp_sensor_emulator: random pattern/en/reset stimulus against a raster-index model of the sensor stream.
module tb_dvp_sensor_emulator;
  localparam int HA = 8, HB = 4, VA = 4, VS = 1, VB = 1, VF = 1, PH = 2;
  localparam int LW = HA + HB, FP = (VS + VB + VA + VF) * LW;
  logic clk = 0, rst = 1, en = 1;
  logic [1:0] pat_sel = 2'd1;
  logic [7:0] dat_i = 0;
  logic [18:0] adr_o;
  logic Pclk, Vsync, Href, busy;
  logic [7:0] Imagen, frame_cnt;
  int n_vec = 0, n_err = 0;
  int t = 0, fs = -1, fc = 0, mode = 0;
  logic [18:0] m_adr = 0;
  bit m_act = 0;
  int m_x = 0;
  logic [7:0] bars [8] = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) dat_i <= adr_o[7:0];

  dvp_sensor_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_FRONT(VF), .PCLK_HALF(PH)) dut (
    .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel), .dat_i(dat_i), .adr_o(adr_o),
    .Pclk(Pclk), .Vsync(Vsync), .Href(Href), .Imagen(Imagen), .frame_cnt(frame_cnt), .busy(busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %h expected %h", tag, t, got, exp);
    end
  endtask

  task automatic step();
    int p, line, x;
    logic [7:0] img;
    logic vs, bz;
    @(negedge clk);
    if (rst) begin
      t = 0; fs = -1; fc = 0; m_adr = 0;
    end else begin
      t++;
      if (t % (2 * PH) == 0) begin
        p = t / (2 * PH) - 1;
        if (fs >= 0 && p - fs == FP) begin fc = (fc + 1) % 256; fs = -1; end
        if (fs < 0 && en) begin fs = p; mode = pat_sel; m_adr = 0; end
      end
      if (t % (2 * PH) == PH && fs >= 0) begin
        p = (t - PH) / (2 * PH) - fs; line = p / LW; x = p % LW;
        if (p < FP && line >= VS + VB && line < VS + VB + VA && x < HA)
          m_adr = 19'((line - VS - VB) * HA + x);
      end
    end
    vs = 0; bz = 0; img = 0; m_act = 0; m_x = 0;
    if (fs >= 0) begin
      p = t / (2 * PH) - 1 - fs; line = p / LW; x = p % LW;
      vs = line < VS; bz = 1; m_x = x;
      m_act = line >= VS + VB && line < VS + VB + VA && x < HA;
      if (m_act)
        img = mode == 0 ? bars[x / (HA / 8)] : mode == 1 ? 8'(x) : mode == 2 ? 8'(fc) :
              8'((line - VS - VB) * HA + x);
    end
    check("sync", {Pclk, Vsync, Href, busy}, {1'((t / PH) % 2), vs, m_act, bz});
    check("pix", Imagen, img);
    check("fcnt", frame_cnt, fc);
    check("adr", adr_o, m_adr);
  endtask

  task automatic run(input int n, input int psel_rate, input int en_rate);
    for (int i = 0; i < n; i++) begin
      if (psel_rate != 0 && $urandom_range(psel_rate - 1) == 0) pat_sel = 2'($urandom);
      if (en_rate != 0 && $urandom_range(en_rate - 1) == 0) en = ~en;
      step();
    end
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 3; i++) step();
    rst = 0;
    run(340, 0, 0);
    pat_sel = 2'd0; run(340, 0, 0);
    pat_sel = 2'd3; run(700, 0, 0);
    run(1200, 40, 0);
    run(150, 0, 0);
    en = 0; run(500, 0, 0);
    en = 1; pat_sel = 2'd2; run(1100, 0, 0);
    run(1500, 30, 60);
    en = 1;
    hit = 0;
    for (int i = 0; i < 800 && !hit; i++) begin
      step();
      hit = m_act && m_x == 3;
    end
    check("reach_active", 32'(hit), 32'd1);
    rst = 1; step();
    rst = 0; run(400, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
